gf180mcu_clkgate_ctrl: RTL and testbench



---
 rtl/gf180mcu_clkgate_pkg.sv | 20 ++
 rtl/gf180mcu_clkgate_dncnt.sv | 33 +++
 rtl/gf180mcu_clkgate_ctrl.sv | 130 +++++++++++++
 tb/tb_gf180mcu_clkgate_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_clkgate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_clkgate_pkg
// Purpose  : Shared types and constants for the clock-gate sink controller.
// Revision : 1.0 - initial release
// ============================================================================
package gf180mcu_clkgate_pkg;

    localparam int STATE_W = 2;
    localparam int STATS_W = 16;

    typedef enum logic [STATE_W-1:0] {
        S_OFF   = 2'd0,
        S_WAKE  = 2'd1,
        S_ON    = 2'd2,
        S_DRAIN = 2'd3
    } clkgate_state_e;

endpackage : gf180mcu_clkgate_pkg
`default_nettype wire

// File: rtl/gf180mcu_clkgate_dncnt.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_clkgate_dncnt
// Purpose  : Loadable down-counter with zero flag; holds at zero.
// Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_clkgate_dncnt #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             LOAD,
    input  logic [CNT_W-1:0] LOAD_VAL,
    input  logic             DEC,
    output logic             ZERO
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_cnt <= '0;
        end else if (LOAD) begin
            r_cnt <= LOAD_VAL;
        end else if (DEC && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign ZERO = (r_cnt == '0);

endmodule : gf180mcu_clkgate_dncnt
`default_nettype wire

// File: rtl/gf180mcu_clkgate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_clkgate_ctrl
// Purpose  : Sink-side REQ/ACK clock-gate controller with wake settle and
//            idle auto-gating. GF180_CLKGATE_STATS_EN adds a wake counter.
// Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_clkgate_ctrl
    import gf180mcu_clkgate_pkg::*;
#(
    parameter int WAKE_CYC = 4,
    parameter int IDLE_CYC = 16,
    parameter int CNT_W    = 8
) (
    input  logic               CLK,
    input  logic               RN,
    input  logic               REQ,
    input  logic               BUSY,
    input  logic               FORCE_ON,
    output logic               CLKEN,
    output logic               ACK,
    output logic [STATE_W-1:0] STATE
`ifdef GF180_CLKGATE_STATS_EN
    ,
    output logic [STATS_W-1:0] WAKE_CNT
`endif
);

    localparam logic [CNT_W-1:0] c_WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] c_IDLE_LOAD = CNT_W'(IDLE_CYC - 1);

    clkgate_state_e   r_state;
    clkgate_state_e   w_next_state;
    logic             r_clken;
    logic             r_ack;
    logic             w_load;
    logic             w_dec;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_load_val;

    gf180mcu_clkgate_dncnt #(
        .CNT_W (CNT_W)
    ) u_dncnt (
        .CLK      (CLK),
        .RN       (RN),
        .LOAD     (w_load),
        .LOAD_VAL (w_load_val),
        .DEC      (w_dec),
        .ZERO     (w_cnt_zero)
    );

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_load_val   = c_IDLE_LOAD;
        case (r_state)
            S_OFF: begin
                if (REQ) begin
                    w_next_state = S_WAKE;
                    w_load       = 1'b1;
                    w_load_val   = c_WAKE_LOAD;
                end
            end
            S_WAKE: begin
                if (!REQ) begin
                    w_next_state = S_DRAIN;
                    w_load       = 1'b1;
                end else if (w_cnt_zero) begin
                    w_next_state = S_ON;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_ON: begin
                if (!REQ && !BUSY) begin
                    w_next_state = S_DRAIN;
                    w_load       = 1'b1;
                end
            end
            S_DRAIN: begin
                // Clock is still running, so a new request skips the wake delay.
                if (REQ) begin
                    w_next_state = S_ON;
                end else if (BUSY) begin
                    w_load = 1'b1;
                end else if (w_cnt_zero) begin
                    w_next_state = S_OFF;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: begin
                w_next_state = S_OFF;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_state <= S_OFF;
            r_clken <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_clken <= (w_next_state != S_OFF) | FORCE_ON;
            r_ack   <= (w_next_state == S_ON);
        end
    end

    assign CLKEN = r_clken;
    assign ACK   = r_ack;
    assign STATE = r_state;

`ifdef GF180_CLKGATE_STATS_EN
    logic [STATS_W-1:0] r_wake_cnt;

    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_wake_cnt <= '0;
        end else if ((r_state == S_OFF) && (w_next_state == S_WAKE) && (r_wake_cnt != '1)) begin
            r_wake_cnt <= r_wake_cnt + 1'b1;
        end
    end

    assign WAKE_CNT = r_wake_cnt;
`endif

endmodule : gf180mcu_clkgate_ctrl
`default_nettype wire

// File: tb/tb_gf180mcu_clkgate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf180mcu_clkgate_ctrl
// Purpose  : Self-checking bench; per-cycle stimulus/expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf180mcu_clkgate_ctrl;

    logic       CLK = 1'b0;
    logic       RN = 1'b0;
    logic       REQ = 1'b0;
    logic       BUSY = 1'b0;
    logic       FORCE_ON = 1'b0;
    logic       CLKEN;
    logic       ACK;
    logic [1:0] STATE;
`ifdef GF180_CLKGATE_STATS_EN
    logic [15:0] WAKE_CNT;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       rn;
        logic       req;
        logic       busy;
        logic       frc;
        logic [1:0] st;
        logic       ce;
        logic       ack;
    } row_t;

    row_t q[$];

    always #5 CLK = ~CLK;

    gf180mcu_clkgate_ctrl #(
        .WAKE_CYC (4),
        .IDLE_CYC (16),
        .CNT_W    (8)
    ) dut (
        .CLK      (CLK),
        .RN       (RN),
        .REQ      (REQ),
        .BUSY     (BUSY),
        .FORCE_ON (FORCE_ON),
        .CLKEN    (CLKEN),
        .ACK      (ACK),
        .STATE    (STATE)
`ifdef GF180_CLKGATE_STATS_EN
        ,
        .WAKE_CNT (WAKE_CNT)
`endif
    );

    // Expected state after an edge with the given inputs applied before it.
    function automatic void push_n(input int n, input logic rn, input logic req,
                                   input logic busy, input logic frc,
                                   input logic [1:0] st, input logic ce, input logic ack);
        for (int i = 0; i < n; i++) q.push_back({rn, req, busy, frc, st, ce, ack});
    endfunction

    // REQ rising from OFF: four WAKE cycles, then ON with ACK.
    function automatic void push_wake();
        push_n(4, 1, 1, 0, 0, 2'd1, 1, 0);
        push_n(1, 1, 1, 0, 0, 2'd2, 1, 1);
    endfunction

    task automatic test_reset();
        row_t r;
        int   idx = 0;
        push_n(1, 0, 0, 0, 0, 2'd0, 0, 0);
        push_n(2, 0, 1, 1, 1, 2'd0, 0, 0);
        while (q.size() > 0) begin
            r = q.pop_front();
            RN = r.rn; REQ = r.req; BUSY = r.busy; FORCE_ON = r.frc;
            @(posedge CLK); #1;
            checks++;
            if ({STATE, CLKEN, ACK} !== {r.st, r.ce, r.ack}) begin
                errors++;
                $display("FAIL reset step %0d: got state=%0d clken=%b ack=%b, want state=%0d clken=%b ack=%b",
                         idx, STATE, CLKEN, ACK, r.st, r.ce, r.ack);
            end
            idx++;
        end
    endtask

    task automatic test_wake_and_idle();
        row_t r;
        int   idx = 0;
        push_n(1, 1, 0, 0, 0, 2'd0, 0, 0);
        push_wake();
        push_n(2, 1, 1, 0, 0, 2'd2, 1, 1);
        push_n(16, 1, 0, 0, 0, 2'd3, 1, 0);
        push_n(2, 1, 0, 0, 0, 2'd0, 0, 0);
        while (q.size() > 0) begin
            r = q.pop_front();
            RN = r.rn; REQ = r.req; BUSY = r.busy; FORCE_ON = r.frc;
            @(posedge CLK); #1;
            checks++;
            if ({STATE, CLKEN, ACK} !== {r.st, r.ce, r.ack}) begin
                errors++;
                $display("FAIL wake_idle step %0d: got state=%0d clken=%b ack=%b, want state=%0d clken=%b ack=%b",
                         idx, STATE, CLKEN, ACK, r.st, r.ce, r.ack);
            end
            idx++;
        end
    endtask

    task automatic test_busy_hold();
        row_t r;
        int   idx = 0;
        push_wake();
        push_n(3, 1, 0, 1, 0, 2'd2, 1, 1);
        push_n(3, 1, 0, 0, 0, 2'd3, 1, 0);
        push_n(10, 1, 0, 1, 0, 2'd3, 1, 0);
        push_n(15, 1, 0, 0, 0, 2'd3, 1, 0);
        push_n(1, 1, 0, 0, 0, 2'd0, 0, 0);
        while (q.size() > 0) begin
            r = q.pop_front();
            RN = r.rn; REQ = r.req; BUSY = r.busy; FORCE_ON = r.frc;
            @(posedge CLK); #1;
            checks++;
            if ({STATE, CLKEN, ACK} !== {r.st, r.ce, r.ack}) begin
                errors++;
                $display("FAIL busy_hold step %0d: got state=%0d clken=%b ack=%b, want state=%0d clken=%b ack=%b",
                         idx, STATE, CLKEN, ACK, r.st, r.ce, r.ack);
            end
            idx++;
        end
    endtask

    task automatic test_fast_regrant();
        row_t r;
        int   idx = 0;
        push_wake();
        // Drain counter at 3, then re-request.
        push_n(13, 1, 0, 0, 0, 2'd3, 1, 0);
        push_n(2, 1, 1, 0, 0, 2'd2, 1, 1);
        // Drain counter at 0: REQ still wins over gating.
        push_n(16, 1, 0, 0, 0, 2'd3, 1, 0);
        push_n(1, 1, 1, 0, 0, 2'd2, 1, 1);
        // BUSY and REQ together in DRAIN.
        push_n(1, 1, 0, 0, 0, 2'd3, 1, 0);
        push_n(1, 1, 1, 1, 0, 2'd2, 1, 1);
        push_n(16, 1, 0, 0, 0, 2'd3, 1, 0);
        push_n(1, 1, 0, 0, 0, 2'd0, 0, 0);
        while (q.size() > 0) begin
            r = q.pop_front();
            RN = r.rn; REQ = r.req; BUSY = r.busy; FORCE_ON = r.frc;
            @(posedge CLK); #1;
            checks++;
            if ({STATE, CLKEN, ACK} !== {r.st, r.ce, r.ack}) begin
                errors++;
                $display("FAIL fast_regrant step %0d: got state=%0d clken=%b ack=%b, want state=%0d clken=%b ack=%b",
                         idx, STATE, CLKEN, ACK, r.st, r.ce, r.ack);
            end
            idx++;
        end
    endtask

    task automatic test_wake_abort();
        row_t r;
        int   idx = 0;
        push_n(1, 1, 1, 0, 0, 2'd1, 1, 0);
        push_n(16, 1, 0, 0, 0, 2'd3, 1, 0);
        push_n(2, 1, 0, 0, 0, 2'd0, 0, 0);
        while (q.size() > 0) begin
            r = q.pop_front();
            RN = r.rn; REQ = r.req; BUSY = r.busy; FORCE_ON = r.frc;
            @(posedge CLK); #1;
            checks++;
            if ({STATE, CLKEN, ACK} !== {r.st, r.ce, r.ack}) begin
                errors++;
                $display("FAIL wake_abort step %0d: got state=%0d clken=%b ack=%b, want state=%0d clken=%b ack=%b",
                         idx, STATE, CLKEN, ACK, r.st, r.ce, r.ack);
            end
            idx++;
        end
    endtask

    task automatic test_reset_force();
        row_t r;
        int   idx = 0;
        push_wake();
        push_n(1, 0, 1, 0, 0, 2'd0, 0, 0);
        push_n(1, 1, 0, 0, 0, 2'd0, 0, 0);
        push_n(3, 1, 0, 0, 1, 2'd0, 1, 0);
        push_n(1, 1, 1, 0, 1, 2'd1, 1, 0);
        push_n(16, 1, 0, 0, 1, 2'd3, 1, 0);
        push_n(1, 1, 0, 0, 1, 2'd0, 1, 0);
        push_n(1, 1, 0, 0, 0, 2'd0, 0, 0);
        while (q.size() > 0) begin
            r = q.pop_front();
            RN = r.rn; REQ = r.req; BUSY = r.busy; FORCE_ON = r.frc;
            @(posedge CLK); #1;
            checks++;
            if ({STATE, CLKEN, ACK} !== {r.st, r.ce, r.ack}) begin
                errors++;
                $display("FAIL reset_force step %0d: got state=%0d clken=%b ack=%b, want state=%0d clken=%b ack=%b",
                         idx, STATE, CLKEN, ACK, r.st, r.ce, r.ack);
            end
            idx++;
        end
    endtask

`ifdef GF180_CLKGATE_STATS_EN
    task automatic test_stats();
        row_t r;
        int   idx = 0;
        push_n(1, 0, 0, 0, 0, 2'd0, 0, 0);
        while (q.size() > 0) begin
            r = q.pop_front();
            RN = r.rn; REQ = r.req; BUSY = r.busy; FORCE_ON = r.frc;
            @(posedge CLK); #1;
        end
        checks++;
        if (WAKE_CNT !== 16'd0) begin
            errors++;
            $display("FAIL stats_clear: got wake_cnt=%0d, want 0", WAKE_CNT);
        end
        for (int w = 0; w < 3; w++) begin
            push_n(1, 1, 1, 0, 0, 2'd1, 1, 0);
            push_n(16, 1, 0, 0, 0, 2'd3, 1, 0);
            push_n(1, 1, 0, 0, 0, 2'd0, 0, 0);
        end
        while (q.size() > 0) begin
            r = q.pop_front();
            RN = r.rn; REQ = r.req; BUSY = r.busy; FORCE_ON = r.frc;
            @(posedge CLK); #1;
            checks++;
            if ({STATE, CLKEN, ACK} !== {r.st, r.ce, r.ack}) begin
                errors++;
                $display("FAIL stats_seq step %0d: got state=%0d clken=%b ack=%b, want state=%0d clken=%b ack=%b",
                         idx, STATE, CLKEN, ACK, r.st, r.ce, r.ack);
            end
            idx++;
        end
        checks++;
        if (WAKE_CNT !== 16'd3) begin
            errors++;
            $display("FAIL stats_count: got wake_cnt=%0d, want 3", WAKE_CNT);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_wake_and_idle();
        test_busy_hold();
        test_fast_regrant();
        test_wake_abort();
        test_reset_force();
`ifdef GF180_CLKGATE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_gf180mcu_clkgate_ctrl
`default_nettype wire
